// File: rtl/pc_next_ctrl.sv
// Next-PC generator: selects the fetch address, diverts illegal targets to the trap
// handler, buffers redirects raised under stall and produces the fetch-kill window.
module pc_next_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR    = 32'h0000_0000,
    parameter logic [XLEN-1:0] IT_RAM_DEPTH = 32'h0000_1000,
    parameter logic [XLEN-1:0] TRAP_ADDR    = 32'h0000_0100,
    parameter int              KILL_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            stall,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_target,
    output logic            pc_write_en,
    output logic [XLEN-1:0] pc_write_addr,
    output logic            fetch_valid,
    output logic            addr_fault,
    output logic [XLEN-1:0] fault_addr,
    output logic            redirect_pending
);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [1:0]    KILL_LOAD = 2'(KILL_CYCLES);
    localparam logic [XLEN:0] SEQ_INC   = {{(XLEN-2){1'b0}}, 3'b100};

    // Extra top bit keeps BOOT_ADDR+IT_RAM_DEPTH and pc_addr+4 from wrapping.
    function automatic logic addr_legal(input logic [XLEN:0] a);
        logic [XLEN:0] lo;
        logic [XLEN:0] hi;
        lo = {1'b0, BOOT_ADDR};
        hi = {1'b0, BOOT_ADDR} + {1'b0, IT_RAM_DEPTH};
        return (a >= lo) && (a < hi) && (a[1:0] == 2'b00);
    endfunction

    state_t          state_r, next_state_s;
    logic            pend_valid_r, pend_valid_s;
    logic            pend_br_r, pend_br_s;
    logic [XLEN-1:0] pend_addr_r, pend_addr_s;
    logic [1:0]      kill_cnt_r;
    logic            addr_fault_r;
    logic [XLEN-1:0] fault_addr_r;
    logic            wr_en_s;
    logic            redirect_s;
    logic            fault_s;
    logic [XLEN:0]   sel_addr_s;
    logic [XLEN-1:0] wr_addr_s;

    // Source selection, pending-buffer update and legality diversion.
    always_comb begin
        next_state_s = state_r;
        pend_valid_s = pend_valid_r;
        pend_br_s    = pend_br_r;
        pend_addr_s  = pend_addr_r;
        wr_en_s      = 1'b0;
        redirect_s   = 1'b0;
        fault_s      = 1'b0;
        sel_addr_s   = {1'b0, pc_addr};
        wr_addr_s    = pc_addr;
        case (state_r)
            BOOT: begin
                next_state_s = RUN;
            end
            RUN, HOLD: begin
                if (trap_req) begin
                    wr_en_s      = 1'b1;
                    redirect_s   = 1'b1;
                    sel_addr_s   = {1'b0, trap_target};
                    pend_valid_s = 1'b0;
                    next_state_s = RUN;
                end else if (stall) begin
                    // A branch outranks any buffered entry; a jump only replaces a jump.
                    if (br_taken) begin
                        pend_valid_s = 1'b1;
                        pend_br_s    = 1'b1;
                        pend_addr_s  = br_target;
                    end else if (jmp_en && !(pend_valid_r && pend_br_r)) begin
                        pend_valid_s = 1'b1;
                        pend_br_s    = 1'b0;
                        pend_addr_s  = jmp_target;
                    end else begin
                        pend_valid_s = pend_valid_r;
                    end
                    next_state_s = pend_valid_s ? HOLD : RUN;
                end else if (pend_valid_r) begin
                    wr_en_s      = 1'b1;
                    redirect_s   = 1'b1;
                    sel_addr_s   = {1'b0, pend_addr_r};
                    pend_valid_s = 1'b0;
                    next_state_s = RUN;
                end else if (br_taken) begin
                    wr_en_s    = 1'b1;
                    redirect_s = 1'b1;
                    sel_addr_s = {1'b0, br_target};
                end else if (jmp_en) begin
                    wr_en_s    = 1'b1;
                    redirect_s = 1'b1;
                    sel_addr_s = {1'b0, jmp_target};
                end else begin
                    wr_en_s    = 1'b1;
                    sel_addr_s = {1'b0, pc_addr} + SEQ_INC;
                end
            end
            default: begin
                next_state_s = BOOT;
            end
        endcase

        if (wr_en_s && !addr_legal(sel_addr_s)) begin
            fault_s    = 1'b1;
            redirect_s = 1'b1;
            wr_addr_s  = TRAP_ADDR;
        end else if (wr_en_s) begin
            wr_addr_s = sel_addr_s[XLEN-1:0];
        end else if (state_r == BOOT) begin
            wr_addr_s = BOOT_ADDR;
        end else begin
            wr_addr_s = pc_addr;
        end
    end

    // State, pending buffer, kill counter and fault capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= BOOT;
            pend_valid_r <= 1'b0;
            pend_br_r    <= 1'b0;
            pend_addr_r  <= {XLEN{1'b0}};
            kill_cnt_r   <= 2'd0;
            addr_fault_r <= 1'b0;
            fault_addr_r <= {XLEN{1'b0}};
        end else begin
            state_r      <= next_state_s;
            pend_valid_r <= pend_valid_s;
            pend_br_r    <= pend_br_s;
            pend_addr_r  <= pend_addr_s;
            addr_fault_r <= fault_s;
            if (fault_s) begin
                fault_addr_r <= sel_addr_s[XLEN-1:0];
            end else begin
                fault_addr_r <= fault_addr_r;
            end
            if (redirect_s) begin
                kill_cnt_r <= KILL_LOAD;
            end else if (kill_cnt_r != 2'd0) begin
                kill_cnt_r <= kill_cnt_r - 2'd1;
            end else begin
                kill_cnt_r <= kill_cnt_r;
            end
        end
    end

    assign pc_write_en      = wr_en_s;
    assign pc_write_addr    = wr_addr_s;
    assign fetch_valid      = (state_r != BOOT) && (kill_cnt_r == 2'd0);
    assign addr_fault       = addr_fault_r;
    assign fault_addr       = fault_addr_r;
    assign redirect_pending = pend_valid_r;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl: one task per scenario with inline comparisons
// against hand-computed values.
module tb_pc_next_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_addr = 32'h0;
    logic        stall = 1'b0;
    logic        jmp_en = 1'b0;
    logic [31:0] jmp_target = 32'h0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_target = 32'h0;
    logic        pc_write_en;
    logic [31:0] pc_write_addr;
    logic        fetch_valid;
    logic        addr_fault;
    logic [31:0] fault_addr;
    logic        redirect_pending;

    int n_cmp = 0;
    int n_err = 0;

    pc_next_ctrl dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .stall(stall),
        .jmp_en(jmp_en), .jmp_target(jmp_target),
        .br_taken(br_taken), .br_target(br_target),
        .trap_req(trap_req), .trap_target(trap_target),
        .pc_write_en(pc_write_en), .pc_write_addr(pc_write_addr),
        .fetch_valid(fetch_valid), .addr_fault(addr_fault),
        .fault_addr(fault_addr), .redirect_pending(redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        n_cmp++; if (pc_write_en !== 1'b0) begin n_err++; $display("FAIL rst_en got=%b exp=0", pc_write_en); end
        n_cmp++; if (pc_write_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", pc_write_addr); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_fv got=%b exp=0", fetch_valid); end
        n_cmp++; if (redirect_pending !== 1'b0 || addr_fault !== 1'b0) begin n_err++; $display("FAIL rst_flags rp=%b af=%b exp=0", redirect_pending, addr_fault); end
        rst = 1'b0; pc_addr = 32'h0; #1;
        n_cmp++; if (pc_write_en !== 1'b0 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL boot_cycle en=%b fv=%b exp=0/0", pc_write_en, fetch_valid); end
        tick; #1;
        n_cmp++; if (pc_write_en !== 1'b1 || pc_write_addr !== 32'h4 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL seq0 en=%b addr=%h fv=%b exp=1/4/1", pc_write_en, pc_write_addr, fetch_valid); end
        tick; pc_addr = 32'h4; #1;
        n_cmp++; if (pc_write_en !== 1'b1 || pc_write_addr !== 32'h8 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL seq1 en=%b addr=%h fv=%b exp=1/8/1", pc_write_en, pc_write_addr, fetch_valid); end
        tick; pc_addr = 32'h8; #1;
        n_cmp++; if (pc_write_en !== 1'b1 || pc_write_addr !== 32'hC || fetch_valid !== 1'b1) begin n_err++; $display("FAIL seq2 en=%b addr=%h fv=%b exp=1/c/1", pc_write_en, pc_write_addr, fetch_valid); end
    endtask

    task automatic test_br_jmp;
        tick; pc_addr = 32'h20;
        br_taken = 1'b1; br_target = 32'h80; jmp_en = 1'b1; jmp_target = 32'h40; #1;
        n_cmp++; if (pc_write_en !== 1'b1 || pc_write_addr !== 32'h80) begin n_err++; $display("FAIL br_over_jmp en=%b addr=%h exp=1/80", pc_write_en, pc_write_addr); end
        tick; br_taken = 1'b0; jmp_en = 1'b0; pc_addr = 32'h80; #1;
        n_cmp++; if (fetch_valid !== 1'b0 || pc_write_addr !== 32'h84) begin n_err++; $display("FAIL kill1 fv=%b addr=%h exp=0/84", fetch_valid, pc_write_addr); end
        tick; pc_addr = 32'h84; #1;
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL kill2 fv=%b exp=0", fetch_valid); end
        tick; pc_addr = 32'h88; #1;
        n_cmp++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL kill_end fv=%b exp=1", fetch_valid); end
    endtask

    task automatic test_stall_pending;
        tick; stall = 1'b1; jmp_en = 1'b1; jmp_target = 32'h200; #1;
        n_cmp++; if (pc_write_en !== 1'b0) begin n_err++; $display("FAIL stall1_en got=%b exp=0", pc_write_en); end
        tick; jmp_en = 1'b0; br_taken = 1'b1; br_target = 32'h300; #1;
        n_cmp++; if (pc_write_en !== 1'b0 || redirect_pending !== 1'b1) begin n_err++; $display("FAIL stall2 en=%b rp=%b exp=0/1", pc_write_en, redirect_pending); end
        tick; br_taken = 1'b0; #1;
        n_cmp++; if (pc_write_en !== 1'b0 || redirect_pending !== 1'b1) begin n_err++; $display("FAIL stall3 en=%b rp=%b exp=0/1", pc_write_en, redirect_pending); end
        tick; stall = 1'b0; #1;
        n_cmp++; if (pc_write_en !== 1'b1 || pc_write_addr !== 32'h300) begin n_err++; $display("FAIL pend_issue en=%b addr=%h exp=1/300", pc_write_en, pc_write_addr); end
        tick; pc_addr = 32'h300; #1;
        n_cmp++; if (redirect_pending !== 1'b0 || fetch_valid !== 1'b0 || pc_write_addr !== 32'h304) begin n_err++; $display("FAIL pend_after rp=%b fv=%b addr=%h exp=0/0/304", redirect_pending, fetch_valid, pc_write_addr); end
    endtask

    task automatic test_fault;
        br_taken = 1'b1; br_target = 32'h1000; #1;
        n_cmp++; if (pc_write_en !== 1'b1 || pc_write_addr !== 32'h100) begin n_err++; $display("FAIL range_divert en=%b addr=%h exp=1/100", pc_write_en, pc_write_addr); end
        tick; br_taken = 1'b0; pc_addr = 32'h100; #1;
        n_cmp++; if (addr_fault !== 1'b1 || fault_addr !== 32'h1000) begin n_err++; $display("FAIL range_fault af=%b fa=%h exp=1/1000", addr_fault, fault_addr); end
        tick; pc_addr = 32'h104; #1;
        n_cmp++; if (addr_fault !== 1'b0 || fault_addr !== 32'h1000) begin n_err++; $display("FAIL fault_pulse af=%b fa=%h exp=0/1000", addr_fault, fault_addr); end
        br_taken = 1'b1; br_target = 32'h42; #1;
        n_cmp++; if (pc_write_addr !== 32'h100) begin n_err++; $display("FAIL align_divert addr=%h exp=100", pc_write_addr); end
        tick; br_taken = 1'b0; pc_addr = 32'h100; #1;
        n_cmp++; if (addr_fault !== 1'b1 || fault_addr !== 32'h42) begin n_err++; $display("FAIL align_fault af=%b fa=%h exp=1/42", addr_fault, fault_addr); end
    endtask

    task automatic test_seq_wrap;
        tick; pc_addr = 32'hFFC; #1;
        n_cmp++; if (pc_write_en !== 1'b1 || pc_write_addr !== 32'h100) begin n_err++; $display("FAIL seq_top en=%b addr=%h exp=1/100", pc_write_en, pc_write_addr); end
        tick; pc_addr = 32'h100; #1;
        n_cmp++; if (addr_fault !== 1'b1 || fault_addr !== 32'h1000 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL seq_fault af=%b fa=%h fv=%b exp=1/1000/0", addr_fault, fault_addr, fetch_valid); end
    endtask

    task automatic test_trap_and_reset;
        tick; stall = 1'b1; jmp_en = 1'b1; jmp_target = 32'h200; #1;
        n_cmp++; if (pc_write_en !== 1'b0) begin n_err++; $display("FAIL trap_pre en=%b exp=0", pc_write_en); end
        tick; jmp_en = 1'b0; trap_req = 1'b1; trap_target = 32'h180; #1;
        n_cmp++; if (pc_write_en !== 1'b1 || pc_write_addr !== 32'h180 || redirect_pending !== 1'b1) begin n_err++; $display("FAIL trap_issue en=%b addr=%h rp=%b exp=1/180/1", pc_write_en, pc_write_addr, redirect_pending); end
        tick; trap_req = 1'b0; stall = 1'b0; pc_addr = 32'h180; #1;
        n_cmp++; if (redirect_pending !== 1'b0 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL trap_after rp=%b fv=%b exp=0/0", redirect_pending, fetch_valid); end
        rst = 1'b1; #1;
        n_cmp++; if (pc_write_en !== 1'b0 || pc_write_addr !== 32'h0 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL midrst_pc en=%b addr=%h fv=%b exp=0/0/0", pc_write_en, pc_write_addr, fetch_valid); end
        n_cmp++; if (addr_fault !== 1'b0 || fault_addr !== 32'h0 || redirect_pending !== 1'b0) begin n_err++; $display("FAIL midrst_flags af=%b fa=%h rp=%b exp=0/0/0", addr_fault, fault_addr, redirect_pending); end
        tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_br_jmp;
        test_stall_pending;
        test_fault;
        test_seq_wrap;
        test_trap_and_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
